right_shift_serializer: RTL and testbench

//   Parallel-in, serial-out transmitter: accepts a SIZE-bit word over a valid/ready handshake
//   and shifts it out LSB-first, one bit per enabled clock. It is the sending end of the

---
 rtl/right_shift_serializer.sv | 96 +++++++++
 tb/tb_right_shift_serializer.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/right_shift_serializer.sv
// Parallel-in, serial-out transmitter: takes a SIZE-bit word on a valid/ready handshake
// and shifts it out LSB-first, one bit per enabled clock, with back-to-back reload.
module right_shift_serializer #(
    parameter int SIZE = 8
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            enable,
    input  logic [SIZE-1:0] data_in,
    input  logic            load_valid,
    output logic            load_ready,
    output logic            out,
    output logic            out_valid,
    output logic            done
);

    localparam int CW = (SIZE > 1) ? $clog2(SIZE) : 1;
    localparam logic [CW-1:0] LAST = CW'(SIZE - 1);

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    state_t          state_q, state_d;
    logic [SIZE-1:0] shreg_q, shreg_d;
    logic [CW-1:0]   cnt_q,   cnt_d;
    logic            done_q,  done_d;
    logic            out_q,   out_d;
    logic            vld_q,   vld_d;
    logic            last_bit;

    // The final bit leaves on this edge; a new word may be taken in the same edge.
    assign last_bit   = (state_q == SHIFT) && enable && (cnt_q == LAST);
    assign load_ready = (state_q == IDLE) || last_bit;

    always_comb begin
        state_d = state_q;
        shreg_d = shreg_q;
        cnt_d   = cnt_q;
        done_d  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (load_valid) begin
                    shreg_d = data_in;
                    cnt_d   = '0;
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                if (enable) begin
                    if (cnt_q == LAST) begin
                        done_d = 1'b1;
                        cnt_d  = '0;
                        if (load_valid) begin
                            shreg_d = data_in;
                        end else begin
                            shreg_d = '0;
                            state_d = IDLE;
                        end
                    end else begin
                        shreg_d = {1'b0, shreg_q[SIZE-1:1]};
                        cnt_d   = cnt_q + 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
        // Serial outputs are registered from the next-state view so they change with the edge.
        vld_d = (state_d == SHIFT);
        out_d = (state_d == SHIFT) && shreg_d[0];
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            shreg_q <= '0;
            cnt_q   <= '0;
            done_q  <= 1'b0;
            out_q   <= 1'b0;
            vld_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            shreg_q <= shreg_d;
            cnt_q   <= cnt_d;
            done_q  <= done_d;
            out_q   <= out_d;
            vld_q   <= vld_d;
        end
    end

    assign out       = out_q;
    assign out_valid = vld_q;
    assign done      = done_q;

endmodule

// File: tb/tb_right_shift_serializer.sv
// Bench for right_shift_serializer: bit-queue reference model, directed vectors with
// literal expectations, and a loopback receiver that must rebuild each word on done.
module tb_right_shift_serializer;
    localparam int SIZE = 8;

    logic            clk = 1'b0;
    logic            reset;
    logic            enable;
    logic [SIZE-1:0] data_in;
    logic            load_valid;
    logic            load_ready;
    logic            out;
    logic            out_valid;
    logic            done;

    int total = 0;
    int bad   = 0;

    right_shift_serializer #(.SIZE(SIZE)) dut (
        .clk        (clk),
        .reset      (reset),
        .enable     (enable),
        .data_in    (data_in),
        .load_valid (load_valid),
        .load_ready (load_ready),
        .out        (out),
        .out_valid  (out_valid),
        .done       (done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference: the bits still to be sent, front = bit on the line.
    bit   bq[$];
    logic done_m  = 1'b0;
    logic started = 1'b0;

    always @(posedge clk) begin
        started <= 1'b1;
        if (reset) begin
            bq.delete();
            done_m <= 1'b0;
        end else begin
            done_m <= (bq.size() == 1) && enable;
            if (enable && bq.size() > 0) begin
                if (bq.size() == 1 && load_valid)
                    for (int k = 0; k < SIZE; k++) bq.push_back(data_in[k]);
                void'(bq.pop_front());
            end else if (bq.size() == 0 && load_valid) begin
                for (int k = 0; k < SIZE; k++) bq.push_back(data_in[k]);
            end
        end
    end

    always @(negedge clk) begin
        if (started) begin
            chk("model_out",   32'(out),        32'((bq.size() > 0) ? bq[0] : 1'b0));
            chk("model_valid", 32'(out_valid),  32'(bq.size() > 0));
            chk("model_done",  32'(done),       32'(done_m));
            chk("model_ready", 32'(load_ready),
                32'((bq.size() == 0) || (bq.size() == 1 && enable)));
        end
    end

    // Loopback receiver: serial-in right shift register fed by out / (out_valid & enable).
    logic [SIZE-1:0] rx = '0;
    always @(posedge clk) begin
        if (out_valid && enable) rx <= {out, rx[SIZE-1:1]};
    end

    logic [SIZE-1:0] sentq[$];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Send one word from idle; enable is 1 every cycle or alternates 1,0,1,0...
    task automatic run_word(input logic [SIZE-1:0] w, input bit toggle, input string tag);
        int idx = 0;
        int cyc = 0;
        logic en;
        load_valid = 1'b1;
        data_in    = w;
        enable     = 1'b1;
        @(negedge clk);
        chk({tag, "_ready_idle"}, 32'(load_ready), 32'd1);
        step();
        load_valid = 1'b0;
        data_in    = ~w;
        while (idx < SIZE && cyc < 4 * SIZE) begin
            en     = toggle ? (cyc % 2 == 0) : 1'b1;
            enable = en;
            @(negedge clk);
            chk({tag, "_bit"},   32'(out),       32'(w[idx]));
            chk({tag, "_valid"}, 32'(out_valid), 32'd1);
            chk({tag, "_nodone"}, 32'(done),     32'd0);
            step();
            if (en) idx++;
            cyc++;
        end
        if (idx < SIZE) begin
            total++; bad++;
            $display("FAIL %s_timeout: got %0d bits expected %0d", tag, idx, SIZE);
        end
        enable = 1'b0;
        @(negedge clk);
        chk({tag, "_done"},      32'(done),      32'd1);
        chk({tag, "_idle_valid"}, 32'(out_valid), 32'd0);
        step();
        @(negedge clk);
        chk({tag, "_done_once"}, 32'(done), 32'd0);
        step();
    endtask

    task automatic lb_done_check();
        if (done) begin
            if (sentq.size() == 0) begin
                total++; bad++;
                $display("FAIL loopback_spurious_done: got done=1 expected no word pending");
            end else begin
                chk("loopback_word", 32'(rx), 32'(sentq.pop_front()));
            end
        end
    endtask

    initial begin
        logic [SIZE-1:0] w1, w2, word;
        int guard;
        logic acc;
        w1 = 8'hB4;
        w2 = 8'h3C;

        // Reset with a word offered: nothing may load.
        reset      = 1'b1;
        load_valid = 1'b1;
        data_in    = 8'hB4;
        enable     = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_out",   32'(out),        32'd0);
        chk("rst_valid", 32'(out_valid),  32'd0);
        chk("rst_done",  32'(done),       32'd0);
        chk("rst_ready", 32'(load_ready), 32'd1);
        step();
        reset      = 1'b0;
        load_valid = 1'b0;
        enable     = 1'b0;
        step();
        @(negedge clk);
        chk("post_rst_valid", 32'(out_valid), 32'd0);
        step();

        run_word(8'hB4, 1'b0, "single");
        run_word(8'hB4, 1'b1, "gaps");

        // Back-to-back: 16 contiguous bits, ready on each last bit.
        load_valid = 1'b1;
        data_in    = w1;
        enable     = 1'b1;
        step();
        data_in    = w2;
        for (int i = 0; i < 2 * SIZE; i++) begin
            @(negedge clk);
            chk("b2b_bit",   32'(out),        32'((i < SIZE) ? w1[i] : w2[i - SIZE]));
            chk("b2b_valid", 32'(out_valid),  32'd1);
            chk("b2b_done",  32'(done),       32'(i == SIZE));
            chk("b2b_ready", 32'(load_ready), 32'(i % SIZE == SIZE - 1));
            step();
            if (i == SIZE - 1) load_valid = 1'b0;
        end
        @(negedge clk);
        chk("b2b_done2",  32'(done),      32'd1);
        chk("b2b_valid2", 32'(out_valid), 32'd0);
        step();

        // Reset after three enabled shifts of 8'hFF.
        load_valid = 1'b1;
        data_in    = 8'hFF;
        enable     = 1'b1;
        step();
        load_valid = 1'b0;
        repeat (3) step();
        reset = 1'b1;
        @(negedge clk);
        chk("mid_pre_out", 32'(out), 32'd1);
        @(posedge clk);
        @(negedge clk);
        chk("mid_out",   32'(out),       32'd0);
        chk("mid_valid", 32'(out_valid), 32'd0);
        chk("mid_done",  32'(done),      32'd0);
        step();
        reset = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("mid_no_done", 32'(done), 32'd0);
            step();
        end
        run_word(8'h5A, 1'b0, "after_rst");

        // Loopback with random words and random enable.
        for (int w = 0; w < 20; w++) begin
            word       = SIZE'($urandom);
            load_valid = 1'b1;
            data_in    = word;
            acc        = 1'b0;
            guard      = 0;
            while (!acc && guard < 200) begin
                enable = 1'($urandom_range(0, 1));
                @(negedge clk);
                acc = load_ready;
                lb_done_check();
                step();
                guard++;
            end
            if (!acc) begin
                total++; bad++;
                $display("FAIL loopback_accept_timeout: got no accept expected accept within 200");
            end else begin
                sentq.push_back(word);
            end
            data_in = ~word;
        end
        load_valid = 1'b0;
        guard      = 0;
        while (sentq.size() > 0 && guard < 400) begin
            enable = 1'($urandom_range(0, 1));
            @(negedge clk);
            lb_done_check();
            step();
            guard++;
        end
        if (sentq.size() > 0) begin
            total++; bad++;
            $display("FAIL loopback_drain: got %0d words pending expected 0", sentq.size());
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got no finish expected finish before time limit");
        $fatal(1, "watchdog");
    end

endmodule
